// File: rtl/rv32i_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package rv32i_fetch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TMR_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DROP,
    VALID,
    FAULT
  } fetch_state_t;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] RV32I_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_timer.sv
// Saturating request-age counter; expire_o flags the last cycle a request may wait for its ack.
module fetch_timer
  import rv32i_fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: reads the word at pc_val over a req/ack memory port, hands it to decode
// with valid/ready, and steps the PC once per accepted instruction.
module instr_fetch
  import rv32i_fetch_pkg::*;
#(
  parameter int unsigned     TIMEOUT_CYCLES = 16,
  parameter logic [XLEN-1:0] NOP_INSTR      = RV32I_NOP
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [XLEN-1:0] pc_val,
  input  logic            flush,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            dec_ready,
  output logic            pc_inc,
  output logic            pc_disable,
  output logic            fetch_err,
  output logic [1:0]      fault_code
);

  fetch_state_t    state_q;
  logic            mem_req_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instr_pc_q;
  logic            instr_valid_q;
  logic            fetch_err_q;
  logic [1:0]      fault_code_q;

  logic busy;
  logic tmr_expire;

  assign busy = (state_q == FETCH) || (state_q == DROP);

  fetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .clr     (clr),
    .clear_i (!busy),
    .en_i    (busy && !mem_ack),
    .expire_o(tmr_expire)
  );

  // PC step controls are combinational so the PC moves in the same cycle decode accepts.
  assign pc_inc     = (state_q == VALID) && dec_ready && !flush;
  assign pc_disable = !(pc_inc || flush);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      fault_code_q  <= FAULT_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pc_val[1:0] != 2'b00) begin
            state_q      <= FAULT;
            fetch_err_q  <= 1'b1;
            fault_code_q <= FAULT_MISALIGN;
          end else begin
            state_q    <= FETCH;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_val;
          end
        end
        // An ack on the last allowed cycle still completes the fetch.
        FETCH: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (flush) begin
              state_q <= IDLE;
            end else begin
              state_q       <= VALID;
              instr_q       <= mem_rdata;
              instr_pc_q    <= mem_addr_q;
              instr_valid_q <= 1'b1;
            end
          end else if (tmr_expire) begin
            state_q      <= FAULT;
            mem_req_q    <= 1'b0;
            fetch_err_q  <= 1'b1;
            fault_code_q <= FAULT_TIMEOUT;
          end else if (flush) begin
            state_q <= DROP;
          end
        end
        // Keep the request up until memory answers, then throw the data away.
        DROP: begin
          if (mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end else if (tmr_expire) begin
            state_q      <= FAULT;
            mem_req_q    <= 1'b0;
            fetch_err_q  <= 1'b1;
            fault_code_q <= FAULT_TIMEOUT;
          end
        end
        VALID: begin
          if (flush) begin
            state_q       <= IDLE;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
          end else if (dec_ready) begin
            state_q       <= IDLE;
            instr_valid_q <= 1'b0;
          end
        end
        FAULT: begin
          if (flush) begin
            state_q      <= IDLE;
            fetch_err_q  <= 1'b0;
            fault_code_q <= FAULT_NONE;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;
  assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table of fetch transactions plus directed flush/fault/reset sequences.
module tb_instr_fetch;

  logic        clk;
  logic        clr;
  logic [31:0] pc_val;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        dec_ready;
  logic        pc_inc;
  logic        pc_disable;
  logic        fetch_err;
  logic [1:0]  fault_code;

  instr_fetch #(
    .TIMEOUT_CYCLES(16),
    .NOP_INSTR     (32'h0000_0013)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .pc_val     (pc_val),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .dec_ready  (dec_ready),
    .pc_inc     (pc_inc),
    .pc_disable (pc_disable),
    .fetch_err  (fetch_err),
    .fault_code (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    int unsigned lat;
    int unsigned rdy;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } row_t;

  exp_t        sb[$];
  row_t        rows[5];
  int          errors = 0;
  int          checks = 0;

  int unsigned ack_lat;
  int unsigned req_cnt;
  logic        dropped;
  logic        stray_ack;
  logic        pc_ld;
  logic [31:0] pc_ld_val;

  logic        req_s, valid_s, inc_s, dis_s, err_s;
  logic [1:0]  code_s;
  logic [31:0] addr_s, instr_s, ipc_s;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0)   return 32'h0050_0093;
    if (a == 32'h200) return 32'hDEAD_BEEF;
    return {a[23:0], 8'h13};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: memory model drives, outputs sampled, scoreboard consumes accepts, PC model steps.
  task automatic cyc();
    exp_t e;
    if (mem_req) begin
      req_cnt++;
      if (flush) dropped = 1'b1;
      if (ack_lat != 0 && req_cnt == ack_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = word(pc_val);
        if (!dropped) sb.push_back({mem_rdata, pc_val});
      end else begin
        mem_ack   = stray_ack;
        mem_rdata = 32'hBAD0_BAD0;
      end
    end else begin
      req_cnt   = 0;
      dropped   = 1'b0;
      mem_ack   = stray_ack;
      mem_rdata = 32'hBAD0_BAD0;
    end
    #1;
    req_s   = mem_req;   addr_s  = mem_addr;  valid_s = instr_valid;
    inc_s   = pc_inc;    dis_s   = pc_disable; err_s  = fetch_err;
    code_s  = fault_code; instr_s = instr;     ipc_s  = instr_pc;
    if (valid_s && flush) begin
      if (sb.size() != 0) void'(sb.pop_front());
    end else if (valid_s && dec_ready) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", instr_s, e.instr);
        chk("sb_pc", ipc_s, e.pc);
      end
    end
    @(negedge clk);
    if (inc_s) pc_val = pc_val + 32'd4;
    else if (pc_ld) pc_val = pc_ld_val;
  endtask

  // Complete fetch from IDLE: 1 idle cycle, lat request cycles, rdy stalled VALID cycles, then accept.
  task automatic run_row(input int unsigned lat, input int unsigned rdy,
                         input logic [31:0] ei, input logic [31:0] ep);
    int unsigned total;
    total   = 2 + lat + rdy;
    flush   = 1'b0;
    ack_lat = lat;
    for (int unsigned n = 1; n <= total; n++) begin
      dec_ready = (rdy == 0) || (n == total);
      cyc();
      chk("row_req", 32'(req_s), 32'(n >= 2 && n <= 1 + lat));
      chk("row_valid", 32'(valid_s), 32'(n > 1 + lat));
      chk("row_inc", 32'(inc_s), 32'(n == total));
      chk("row_disable", 32'(dis_s), 32'(n != total));
      if (n >= 2 && n <= 1 + lat) chk("row_addr", addr_s, ep);
      if (n > 1 + lat) begin
        chk("row_instr", instr_s, ei);
        chk("row_ipc", ipc_s, ep);
      end
      if (n == 1) begin
        chk("row_err", 32'(err_s), 32'd0);
        chk("row_code", 32'(code_s), 32'd0);
      end
    end
    dec_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned nreq;
    rows[0] = '{lat: 1,  rdy: 0, exp_instr: 32'h0050_0093, exp_pc: 32'h0};
    rows[1] = '{lat: 1,  rdy: 5, exp_instr: 32'h0000_0413, exp_pc: 32'h4};
    rows[2] = '{lat: 3,  rdy: 0, exp_instr: 32'h0000_0813, exp_pc: 32'h8};
    rows[3] = '{lat: 16, rdy: 1, exp_instr: 32'h0000_0C13, exp_pc: 32'hC};
    rows[4] = '{lat: 2,  rdy: 2, exp_instr: 32'h0000_1013, exp_pc: 32'h10};

    clr = 1'b0; pc_val = 32'h0; flush = 1'b0; dec_ready = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0; ack_lat = 0; req_cnt = 0;
    dropped = 1'b0; stray_ack = 1'b0; pc_ld = 1'b0; pc_ld_val = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_ipc", instr_pc, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_code", 32'(fault_code), 32'd0);
    chk("rst_inc", 32'(pc_inc), 32'd0);
    chk("rst_disable", 32'(pc_disable), 32'd1);
    clr = 1'b1;

    for (int i = 0; i < 5; i++)
      run_row(rows[i].lat, rows[i].rdy, rows[i].exp_instr, rows[i].exp_pc);

    // Flush in the second cycle of a 4-cycle fetch: request held to ack, data dropped, refetch at 0x100.
    ack_lat = 4; dec_ready = 1'b1;
    cyc();                                        chk("fl_idle_req", 32'(req_s), 32'd0);
    cyc();                                        chk("fl_req1", 32'(req_s), 32'd1);
    flush = 1'b1; pc_ld = 1'b1; pc_ld_val = 32'h100;
    cyc();                                        chk("fl_disable", 32'(dis_s), 32'd0);
    flush = 1'b0; pc_ld = 1'b0;
    cyc();                                        chk("fl_req3", 32'(req_s), 32'd1);
                                                  chk("fl_addr3", addr_s, 32'h14);
    cyc();                                        chk("fl_req4", 32'(req_s), 32'd1);
                                                  chk("fl_valid4", 32'(valid_s), 32'd0);
    chk("fl_sb_empty", 32'(sb.size()), 32'd0);
    run_row(2, 0, 32'h0001_0013, 32'h100);

    // Flush in VALID to a misaligned PC, then fault, then recover via flush.
    ack_lat = 1; dec_ready = 1'b0;
    cyc(); cyc(); cyc();                          chk("vf_valid", 32'(valid_s), 32'd1);
    flush = 1'b1; pc_ld = 1'b1; pc_ld_val = 32'h6;
    cyc();                                        chk("vf_inc", 32'(inc_s), 32'd0);
                                                  chk("vf_disable", 32'(dis_s), 32'd0);
    flush = 1'b0; pc_ld = 1'b0;
    cyc();                                        chk("vf_valid0", 32'(valid_s), 32'd0);
                                                  chk("vf_nop", instr_s, 32'h0000_0013);
    cyc();                                        chk("mis_err", 32'(err_s), 32'd1);
                                                  chk("mis_code", 32'(code_s), 32'd1);
                                                  chk("mis_req", 32'(req_s), 32'd0);
                                                  chk("mis_disable", 32'(dis_s), 32'd1);
    cyc();                                        chk("mis_req_hold", 32'(req_s), 32'd0);
                                                  chk("mis_err_hold", 32'(err_s), 32'd1);
    flush = 1'b1; pc_ld = 1'b1; pc_ld_val = 32'h8;
    cyc();
    flush = 1'b0; pc_ld = 1'b0;
    run_row(1, 0, 32'h0000_0813, 32'h8);

    // No ack: request must drop after 16 cycles with a timeout fault; stray ack ignored.
    ack_lat = 0; nreq = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (req_s) nreq++;
      else if (nreq > 0) break;
    end
    chk("to_cycles", nreq, 32'd16);
    chk("to_err", 32'(err_s), 32'd1);
    chk("to_code", 32'(code_s), 32'd2);
    stray_ack = 1'b1;
    cyc();
    stray_ack = 1'b0;
    cyc();                                        chk("stray_err", 32'(err_s), 32'd1);
                                                  chk("stray_code", 32'(code_s), 32'd2);
                                                  chk("stray_valid", 32'(valid_s), 32'd0);
                                                  chk("stray_req", 32'(req_s), 32'd0);
    flush = 1'b1; pc_ld = 1'b1; pc_ld_val = 32'h200;
    cyc();
    flush = 1'b0; pc_ld = 1'b0;

    // Asynchronous reset while holding 0xDEADBEEF in VALID.
    ack_lat = 1; dec_ready = 1'b0;
    cyc(); cyc(); cyc();                          chk("ar_instr", instr_s, 32'hDEAD_BEEF);
                                                  chk("ar_valid", 32'(valid_s), 32'd1);
    #2 clr = 1'b0;
    #1;
    chk("ar_nop", instr, 32'h0000_0013);
    chk("ar_valid0", 32'(instr_valid), 32'd0);
    chk("ar_req0", 32'(mem_req), 32'd0);
    chk("ar_ipc0", instr_pc, 32'h0);
    sb.delete();
    pc_val = 32'h0;
    @(negedge clk);
    clr = 1'b1;
    run_row(1, 0, 32'h0050_0093, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Consumer end of the program-counter interface: takes pc_val, fetches the 32-bit instruction at that address over a req/ack instruction-memory port, and presents it to decode with a valid/ready handshake.
- Drives the PC's step controls: pc_inc and pc_disable.
- The PC advances exactly once per instruction accepted by decode; flush and fault paths let trap/redirect logic reload the PC.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles a memory request may wait for mem_ack before the fetch faults; legal range 2..255.
- NOP_INSTR, 32'h0000_0013: reset/flush value of instr (RV32I addi x0,x0,0).

Ports:
- clk  in  1  clock
- clr  in  1  reset, asynchronous, active-low
- pc_val  in  32  current PC from the program counter
- flush  in  1  discard in-flight/held instruction; PC free to be reloaded this cycle
- mem_req  out  1  instruction-memory request, level
- mem_addr  out  32  request address (= pc_val while mem_req=1)
- mem_ack  in  1  single-cycle completion pulse; mem_rdata valid in same cycle
- mem_rdata  in  32  fetched instruction word
- instr  out  32  instruction to decode
- instr_pc  out  32  address instr was fetched from
- instr_valid  out  1  instr/instr_pc valid
- dec_ready  in  1  decode accepts instr this cycle
- pc_inc  out  1  one-cycle PC advance strobe (drives PC inc)
- pc_disable  out  1  PC hold (drives PC Disable)
- fetch_err  out  1  fault active
- fault_code  out  2  2'b00 none, 2'b01 misaligned pc_val, 2'b10 memory timeout

Behaviour:
- Reset (clr=0, async):
  - state=IDLE; counter=0; instr=NOP_INSTR; instr_pc=0.
  - mem_req=0, instr_valid=0, pc_inc=0, fetch_err=0, fault_code=00.
  - pc_disable=1 after reset release.
- States: IDLE, FETCH, DROP, VALID, FAULT. All outputs are registered or decoded from state only, except pc_inc and pc_disable.
- pc_inc = (state==VALID) & dec_ready & ~flush.
- pc_disable = ~(pc_inc | flush).
- IDLE:
  - mem_req=0.
  - Next cycle: if pc_val[1:0]!=0 -> FAULT with fault_code=01; else -> FETCH with counter=0.
  - One bubble cycle between instructions is required.
- FETCH:
  - mem_req=1; mem_addr=pc_val (PC frozen, so stable); counter increments each cycle without ack.
  - mem_ack & ~flush -> instr<=mem_rdata, instr_pc<=pc_val, -> VALID.
  - mem_ack & flush -> data discarded, -> IDLE.
  - flush & ~mem_ack -> DROP (request stays asserted).
  - counter==TIMEOUT_CYCLES-1 & ~mem_ack -> FAULT, fault_code=10, mem_req deasserts. Memory must tolerate a withdrawn request.
- DROP:
  - mem_req=1, same address, counter continues.
  - mem_ack -> data discarded, -> IDLE.
  - Timeout -> FAULT code 10.
  - flush in DROP: no additional effect.
- VALID:
  - instr_valid=1; instr/instr_pc held stable until state exit.
  - dec_ready & ~flush -> pc_inc pulse this cycle, -> IDLE, instr_valid=0 next cycle.
  - flush -> IDLE, instr=NOP_INSTR, no pc_inc. flush has priority over dec_ready.
- FAULT:
  - fetch_err=1, mem_req=0, instr_valid=0, pc_disable=1.
  - flush -> IDLE, fault_code<=00.
- Latency:
  - Request appears 1 cycle after entering IDLE.
  - instr_valid rises the cycle after mem_ack.
  - Zero-wait memory (ack in first FETCH cycle) gives 3 cycles per instruction with dec_ready held high.
- Counter is 8 bits wide and never wraps: it saturates the FSM into FAULT.
- Reset mid-transaction: all state cleared immediately; a later stray mem_ack in IDLE/FAULT/VALID is ignored.

Decomposition:
- Package rv32i_fetch_pkg:
  - fetch_state_t enum (IDLE, FETCH, DROP, VALID, FAULT)
  - fault code localparams FAULT_NONE/FAULT_MISALIGN/FAULT_TIMEOUT
  - RV32I_NOP constant
- Sub-module fetch_timer: 8-bit counter with clear/enable and an expire output against TIMEOUT_CYCLES-1. Instantiated once.

Test Plan:
- Reset, pc_val=0, ack 1 cycle after req, mem_rdata=32'h00500093, dec_ready=1 -> req at cycle 1, instr_valid with instr=32'h00500093 and instr_pc=0, pc_inc pulse exactly 1 cycle, next req at mem_addr=4 after PC step.
- dec_ready low 5 cycles in VALID -> instr/instr_valid stable, pc_disable=1, pc_inc=0 throughout; single pc_inc when dec_ready rises.
- flush at cycle 2 of a 4-cycle-latency fetch -> mem_req held to ack, ack data discarded (instr_valid stays 0), return to IDLE, refetch from reloaded pc_val=32'h100.
- pc_val=32'h0000_0006 -> no mem_req, fetch_err=1, fault_code=01; flush clears to 00 and fetch resumes once pc_val aligned.
- No mem_ack, TIMEOUT_CYCLES=16 -> mem_req drops after 16th request cycle, fault_code=10; stray ack later ignored.
- clr asserted while in VALID with instr=32'hDEADBEEF -> instr=32'h00000013, instr_valid=0, mem_req=0 immediately (async).
